// File: rtl/gate_stim_capture_if.sv
// gate_stim_capture_if
//   Bundles the run handshake, stimulus/response and readback signals of
//   gate_stim_capture.
//   slave  : the sequencer (drives vec_out, busy, done, rd_data, signature)
//   master : the controller / gate-block side (drives start, resp_in, rd_addr)
`timescale 1ns/1ps
interface gate_stim_capture_if;
  logic       start;      // run request, sampled only in IDLE
  logic [4:0] vec_out;    // stimulus a=[4] .. e=[0]
  logic [2:0] resp_in;    // gate response x=[2] y=[1] z=[0]
  logic       busy;       // high while a run is in progress
  logic       done;       // one-cycle completion pulse
  logic [4:0] rd_addr;    // capture buffer read address
  logic [2:0] rd_data;    // registered buffer read data
  logic [7:0] signature;  // MISR result, valid when busy=0

  modport slave (
    input  start, resp_in, rd_addr,
    output vec_out, busy, done, rd_data, signature
  );

  modport master (
    output start, resp_in, rd_addr,
    input  vec_out, busy, done, rd_data, signature
  );
endinterface

// File: rtl/gate_stim_capture.sv
// gate_stim_capture
//   Exhaustive stimulus sequencer and response capture for a 5-in/3-out
//   combinational gate block. Applies vectors 0..LAST_VEC in order, holds each
//   for SETTLE_CYCLES cycles, samples the response on the last edge of the
//   window into a 32x3 buffer and folds it into an 8-bit MISR.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held (1..16)
//   LAST_VEC      : index of the final vector (0..31)
//
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : gate_stim_capture_if.slave (start, vec_out, resp_in, busy, done,
//           rd_addr, rd_data, signature)
//
// Build option
//   GATE_SIG_EN : when defined the MISR is compiled in; otherwise signature
//                 is tied to 8'h00.
`timescale 1ns/1ps
module gate_stim_capture #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LAST_VEC      = 31
) (
  input  logic               clk,
  input  logic               reset,
  gate_stim_capture_if.slave bus
);

  // SETTLE_CYCLES-1 is at most 15
  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       LAST       = 5'(LAST_VEC);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       vec_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       rd_data_q;
  logic [2:0]       mem [32];

  logic start_acc;
  logic sample;

  assign start_acc = (state_q == S_IDLE) && bus.start;
  // last edge of the settle window for the current vector
  assign sample    = (state_q == S_RUN) && (cnt_q == '0);

  // run sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            vec_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (vec_q == LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            vec_q   <= '0;
          end else begin
            vec_q <= vec_q + 5'd1;
            cnt_q <= CNT_RELOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // capture storage is deliberately not reset so an aborted run keeps what
  // it already captured; write is gated by state, which reset forces to IDLE
  always_ff @(posedge clk) begin
    if (sample) mem[vec_q] <= bus.resp_in;
  end

  // read-before-write: a colliding read returns the old entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[bus.rd_addr];
  end

`ifdef GATE_SIG_EN
  // MISR, x^8+x^6+x^5+x^4+1, restarted from zero on every accepted start
  logic [7:0] sig_q;
  logic       sig_fb;

  assign sig_fb = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sig_q <= '0;
    else if (start_acc) sig_q <= '0;
    else if (sample)    sig_q <= {sig_q[6:0], sig_fb} ^ {5'b0, bus.resp_in};
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = 8'h00;
`endif

  assign bus.vec_out = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: doc/gate_stim_capture.md
# gate_stim_capture

Exhaustive stimulus sequencer and response capture stage for the switch-level gate models. It drives the 5-bit input vector (a..e) of a combinational gate block such as `cmos_gates`, waits a programmable settle time, and samples the 3-bit response (x, y, z) into a 32-entry capture buffer. The buffer can be read back after the run. A running MISR signature gives a one-word pass/fail check. The block sits directly upstream of the gate block on its inputs and directly downstream of it on its outputs.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before its response is sampled; legal range 1..16.
- LAST_VEC, 31: index of the final vector applied; legal range 0..31. Vectors 0..LAST_VEC are applied in order.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- vec_out  out  5  stimulus; a=[4], b=[3], c=[2], d=[1], e=[0].
- resp_in  in  3  gate response; x=[2], y=[1], z=[0].
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- rd_addr  in  5  capture buffer read address.
- rd_data  out  3  registered buffer read data.
- signature  out  8  MISR result, valid when busy=0.

## Operation
- States: IDLE and RUN.
- IDLE, start=1 at an edge:
  - vec_out<=0, settle counter cnt<=SETTLE_CYCLES-1, signature<=0, busy<=1.
  - State goes to RUN.
- RUN, cnt!=0 at an edge: cnt<=cnt-1. vec_out holds.
- RUN, cnt==0 at an edge (sample edge):
  - mem[vec_out]<=resp_in, and the signature updates.
  - If vec_out==LAST_VEC: state<=IDLE, busy<=0, done<=1, vec_out<=0.
  - Otherwise: vec_out<=vec_out+1, cnt<=SETTLE_CYCLES-1.
- done is high for exactly one cycle and is low in every other cycle.
- start while busy=1 is ignored, with no effect on state, counters or signature.
- start in the cycle where done=1 (state is already IDLE) is accepted and begins a new run.
- Signature update, polynomial x^8+x^6+x^5+x^4+1: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {5'b0, resp_in}.
- Capture buffer:
  - 32x3 storage, not reset.
  - Entries above LAST_VEC keep their prior contents.
  - rd_data<=mem[rd_addr] on every edge, in any state.
  - A same-cycle read and write to the same address returns the old data.
- vec_out counts up from 0 and never wraps past LAST_VEC.

## Timing
- Reset values: vec_out=0, busy=0, done=0, rd_data=0, signature=0, state=IDLE, cnt=0.
- Reset asserted mid-run aborts immediately. No done pulse is produced, and buffer contents written so far are retained.
- A run takes exactly (LAST_VEC+1)*SETTLE_CYCLES cycles, from the start-accept edge to the edge that raises done.
- Each vector is presented for SETTLE_CYCLES full cycles. resp_in is sampled at the final edge of that window.
- busy rises on the start-accept edge and falls on the same edge that raises done.
- Read latency is 1 cycle from rd_addr to rd_data.

## Configuration
- GATE_SIG_EN:
  - Defined: the MISR is compiled in and behaves as above.
  - Undefined: the MISR logic is omitted and signature is tied to 8'h00 at all times. All other behaviour is identical.

## Test plan
- Basic run:
  - Setup: SETTLE_CYCLES=2, LAST_VEC=3, resp_in tied to vec_out[2:0], pulse start.
  - Required: vec_out shows 0,1,2,3, each for 2 cycles, and done pulses 8 cycles after the start edge.
  - Required: reading addresses 0..3 returns 0,1,2,3.
  - Required with GATE_SIG_EN: signature=8'h03.
- Full sweep against the gate model:
  - Setup: defaults, with vec_out and resp_in connected to `cmos_gates`.
  - Required: 64 cycles from start to done.
  - Required: the buffer matches the model outputs for vectors 00000, 01010, 10101 and 11111.
- Start while busy:
  - Stimulus: pulse start 3 cycles into a run.
  - Required: vec_out sequence and run length are unchanged, and only one done pulse occurs.
- Back-to-back runs:
  - Stimulus: assert start during the done cycle.
  - Required: busy rises again on the next edge, vec_out=0, signature is restarted from 0.
- Reset mid-run:
  - Stimulus: assert reset while vec_out=2.
  - Required: all outputs return to reset values asynchronously and no done pulse occurs.
  - Required: entries 0..1 remain readable.
- Macro off:
  - Stimulus: rerun the basic run without GATE_SIG_EN.
  - Required: signature stays 8'h00 and the buffer and timing results are identical.
